packet_demux: RTL and testbench



---
 rtl/packet_demux.sv | 267 ++++++++++++++++++++++++++
 tb/tb_packet_demux.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_demux.sv
// packet_demux
// Receive-side data island packet dispatcher. Takes one assembled,
// ECC-corrected packet (header + four 56-bit subpackets) per packet_valid
// strobe and routes it by packet type (HB0):
//   0x01 ACR          -> acr_n / acr_cts registers, acr_valid pulse
//   0x02 Audio Sample -> unpacked slot by slot into a show-ahead sample FIFO
//   0x82/0x83/0x84    -> checksum-checked InfoFrames, tracked per video field
// All other types are ignored.
//
// Ports
//   clk_pixel, reset_n         : sole clock, asynchronous active-low reset
//   packet_valid, header, sub  : packet strobe, HB0..HB2, subpackets 0..3
//   video_field_end            : strobe closing the current video field
//   acr_n, acr_cts, acr_valid  : last Audio Clock Regeneration values + pulse
//   avi_vic                    : VIC from the last good AVI InfoFrame
//   audio_valid/audio_ready    : FIFO head valid / consumer pop
//   audio_sample_word          : [0]=left, [1]=right of the FIFO head
//   audio_block_start          : IEC 60958 B flag of the FIFO head
//   audio_fifo_count           : FIFO occupancy
//   avi_present, audio_if_present, spd_present : InfoFrame seen last field
//   checksum_error             : pulse per InfoFrame with a bad checksum
//   audio_overflow, protocol_error : sticky error flags
//   unpack_active              : debug view of the unpack FSM (1 = UNPACK)
//
// Handshake: a FIFO pop happens at the clock edge where audio_valid and
// audio_ready are both high; the head is stable while audio_valid is high
// and audio_ready is low.
module packet_demux #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                                 clk_pixel,
    input  logic                                 reset_n,
    input  logic                                 packet_valid,
    input  logic [23:0]                          header,
    input  logic [3:0][55:0]                     sub,
    input  logic                                 video_field_end,
    output logic [19:0]                          acr_n,
    output logic [19:0]                          acr_cts,
    output logic                                 acr_valid,
    output logic [6:0]                           avi_vic,
    output logic                                 audio_valid,
    input  logic                                 audio_ready,
    output logic [1:0][AUDIO_BIT_WIDTH-1:0]      audio_sample_word,
    output logic                                 audio_block_start,
    output logic [$clog2(FIFO_DEPTH):0]          audio_fifo_count,
    output logic                                 avi_present,
    output logic                                 audio_if_present,
    output logic                                 spd_present,
    output logic                                 checksum_error,
    output logic                                 audio_overflow,
    output logic                                 protocol_error,
    output logic                                 unpack_active
);

    localparam int W  = AUDIO_BIT_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * W + 1;   // FIFO entry: {B, R, L}

    typedef enum logic {
        IDLE   = 1'b0,
        UNPACK = 1'b1
    } state_t;

    state_t state, state_next;
    logic [1:0] slot, slot_next;

    // ------------------------------------------------------------------
    // Packet classification
    // ------------------------------------------------------------------
    logic [7:0] hb0;
    logic       accept;
    logic       is_acr;
    logic       is_audio;
    logic       is_if;
    logic [7:0] csum;
    logic       if_good;
    logic       if_bad;
    logic [2:0] seen_set;   // [0]=AVI, [1]=Audio InfoFrame, [2]=SPD

    assign hb0    = header[7:0];
    // While unpacking, every incoming packet is dropped.
    assign accept = packet_valid && (state == IDLE);

    always_comb begin
        csum = header[7:0] + header[15:8] + header[23:16];
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 7; j++) begin
                csum = csum + sub[k][8*j +: 8];
            end
        end
    end

    assign is_acr   = accept && (hb0 == 8'h01);
    // HB1[4] set means layout 1, which this block does not unpack.
    assign is_audio = accept && (hb0 == 8'h02) && !header[12];
    assign is_if    = accept && ((hb0 == 8'h82) || (hb0 == 8'h83) || (hb0 == 8'h84));
    assign if_good  = is_if && (csum == 8'h00);
    assign if_bad   = is_if && (csum != 8'h00);

    always_comb begin
        seen_set    = '0;
        seen_set[0] = if_good && (hb0 == 8'h82);
        seen_set[1] = if_good && (hb0 == 8'h84);
        seen_set[2] = if_good && (hb0 == 8'h83);
    end

    // ------------------------------------------------------------------
    // Audio unpack register (samples stored already truncated)
    // ------------------------------------------------------------------
    logic [3:0]        cap_present;
    logic [3:0]        cap_b;
    logic [3:0][W-1:0] cap_l;
    logic [3:0][W-1:0] cap_r;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cap_present <= '0;
            cap_b       <= '0;
            cap_l       <= '0;
            cap_r       <= '0;
        end else if (is_audio) begin
            cap_present <= header[11:8];
            cap_b       <= header[23:20];
            for (int k = 0; k < 4; k++) begin
                cap_l[k] <= sub[k][23 -: W];
                cap_r[k] <= sub[k][47 -: W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Unpack FSM: one slot per cycle, absent slots still take a cycle
    // ------------------------------------------------------------------
    logic          push;
    logic [EW-1:0] push_word;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            slot  <= 2'd0;
        end else begin
            state <= state_next;
            slot  <= slot_next;
        end
    end

    always_comb begin
        state_next = state;
        slot_next  = slot;
        push       = 1'b0;
        push_word  = {cap_b[slot], cap_r[slot], cap_l[slot]};
        case (state)
            IDLE: begin
                if (is_audio) begin
                    state_next = UNPACK;
                    slot_next  = 2'd0;
                end
            end
            UNPACK: begin
                push      = cap_present[slot];
                slot_next = slot + 2'd1;
                if (slot == 2'd3) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign unpack_active = (state == UNPACK);

    // ------------------------------------------------------------------
    // Sample FIFO (show-ahead). Pointers carry one extra wrap bit so
    // full and empty are distinguishable.
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic [EW-1:0] head;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = audio_valid && audio_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_word;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head                 = mem[rd_ptr[AW-1:0]];
    assign audio_valid          = (count != '0);
    assign audio_fifo_count     = count;
    assign audio_sample_word[0] = head[W-1:0];
    assign audio_sample_word[1] = head[2*W-1:W];
    assign audio_block_start    = head[2*W];

    // ------------------------------------------------------------------
    // ACR, InfoFrame and status registers
    // ------------------------------------------------------------------
    logic [2:0] seen;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            acr_n            <= '0;
            acr_cts          <= '0;
            acr_valid        <= 1'b0;
            avi_vic          <= '0;
            checksum_error   <= 1'b0;
            seen             <= '0;
            avi_present      <= 1'b0;
            audio_if_present <= 1'b0;
            spd_present      <= 1'b0;
            audio_overflow   <= 1'b0;
            protocol_error   <= 1'b0;
        end else begin
            acr_valid      <= is_acr;
            checksum_error <= if_bad;
            if (is_acr) begin
                acr_cts <= {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
                acr_n   <= {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
            end
            if (seen_set[0]) begin
                avi_vic <= sub[0][38:32];
            end
            // A good InfoFrame coinciding with the field end belongs to the
            // field that is ending.
            if (video_field_end) begin
                avi_present      <= seen[0] | seen_set[0];
                audio_if_present <= seen[1] | seen_set[1];
                spd_present      <= seen[2] | seen_set[2];
                seen             <= '0;
            end else begin
                seen <= seen | seen_set;
            end
            if (push && !push_ok) begin
                audio_overflow <= 1'b1;
            end
            if (packet_valid && (state == UNPACK)) begin
                protocol_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_packet_demux.sv
// Directed bench for packet_demux (AUDIO_BIT_WIDTH=16, FIFO_DEPTH=8).
// Stimulus pushes expected audio samples / ACR values into queues; monitor
// processes compare them whenever the DUT presents an output.
module tb_packet_demux;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int EW = 2 * W + 1;

    logic                   clk_pixel;
    logic                   reset_n;
    logic                   packet_valid;
    logic [23:0]            header;
    logic [3:0][55:0]       sub;
    logic                   video_field_end;
    logic [19:0]            acr_n;
    logic [19:0]            acr_cts;
    logic                   acr_valid;
    logic [6:0]             avi_vic;
    logic                   audio_valid;
    logic                   audio_ready;
    logic [1:0][W-1:0]      audio_sample_word;
    logic                   audio_block_start;
    logic [$clog2(D):0]     audio_fifo_count;
    logic                   avi_present;
    logic                   audio_if_present;
    logic                   spd_present;
    logic                   checksum_error;
    logic                   audio_overflow;
    logic                   protocol_error;
    logic                   unpack_active;

    packet_demux #(.AUDIO_BIT_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk_pixel         (clk_pixel),
        .reset_n           (reset_n),
        .packet_valid      (packet_valid),
        .header            (header),
        .sub               (sub),
        .video_field_end   (video_field_end),
        .acr_n             (acr_n),
        .acr_cts           (acr_cts),
        .acr_valid         (acr_valid),
        .avi_vic           (avi_vic),
        .audio_valid       (audio_valid),
        .audio_ready       (audio_ready),
        .audio_sample_word (audio_sample_word),
        .audio_block_start (audio_block_start),
        .audio_fifo_count  (audio_fifo_count),
        .avi_present       (avi_present),
        .audio_if_present  (audio_if_present),
        .spd_present       (spd_present),
        .checksum_error    (checksum_error),
        .audio_overflow    (audio_overflow),
        .protocol_error    (protocol_error),
        .unpack_active     (unpack_active)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_pixel = 1'b0;
        forever #5 clk_pixel = ~clk_pixel;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [39:0]   acr_q[$];    // {N, CTS}
    int            total;
    int            bad;
    int            acr_pulses;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected FIFO entry: top 16 bits of each 24-bit sample.
    function automatic logic [EW-1:0] ex(input logic b, input logic [23:0] l, input logic [23:0] r);
        return {b, r[23:8], l[23:8]};
    endfunction

    function automatic logic [55:0] slot_bits(input logic [23:0] l, input logic [23:0] r);
        return {8'h00, r, l};
    endfunction

    // ---------------- monitors ----------------
    initial begin
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        forever begin
            @(negedge clk_pixel);
            if (audio_valid && audio_ready) begin
                act = {audio_block_start, audio_sample_word[1], audio_sample_word[0]};
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL audio_unexpected: got 0x%0h expected no sample", act);
                end else begin
                    e = exp_q.pop_front();
                    chk("audio_sample", 64'(act), 64'(e));
                end
            end
        end
    end

    initial begin
        logic [39:0] e;
        acr_pulses = 0;
        forever begin
            @(negedge clk_pixel);
            if (acr_valid) begin
                acr_pulses++;
                if (acr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL acr_unexpected: got n=0x%0h cts=0x%0h expected no update", acr_n, acr_cts);
                end else begin
                    e = acr_q.pop_front();
                    chk("acr_values", 64'({acr_n, acr_cts}), 64'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; drives one packet cycle and returns at the next posedge+1.
    task automatic send(input logic [23:0] h, input logic [55:0] s0, input logic [55:0] s1,
                        input logic [55:0] s2, input logic [55:0] s3, input logic vfe);
        header          = h;
        sub[0]          = s0;
        sub[1]          = s1;
        sub[2]          = s2;
        sub[3]          = s3;
        packet_valid    = 1'b1;
        video_field_end = vfe;
        @(posedge clk_pixel);
        #1;
        packet_valid    = 1'b0;
        video_field_end = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    task automatic field_end();
        video_field_end = 1'b1;
        idle(1);
        video_field_end = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [55:0] s0;
        logic [55:0] s1;
        logic [55:0] s2;
        logic [55:0] s3;
        logic [23:0] l;
        logic [23:0] r;
        logic [3:0][55:0] ov;
        total           = 0;
        bad             = 0;
        reset_n         = 1'b0;
        packet_valid    = 1'b0;
        header          = '0;
        sub             = '0;
        video_field_end = 1'b0;
        audio_ready     = 1'b1;
        repeat (3) @(posedge clk_pixel);
        #1;
        chk("rst_acr_n", 64'(acr_n), 0);
        chk("rst_audio_valid", 64'(audio_valid), 0);
        chk("rst_fifo_count", 64'(audio_fifo_count), 0);
        chk("rst_flags", 64'({avi_present, audio_if_present, spd_present, checksum_error,
                              audio_overflow, protocol_error, acr_valid}), 0);
        reset_n = 1'b1;
        idle(2);

        // ---- ACR: N=0x01800, CTS=0x1220A ----
        acr_q.push_back({20'h01800, 20'h1220A});
        send(24'h000001, 56'h00_18_00_0A_22_01_00, 56'h0, 56'h0, 56'h0, 1'b0);
        chk("acr_valid_c1", 64'(acr_valid), 1);
        chk("acr_n", 64'(acr_n), 64'h01800);
        chk("acr_cts", 64'(acr_cts), 64'h1220A);
        idle(1);
        chk("acr_valid_c2", 64'(acr_valid), 0);

        // ---- Audio HB1=0x0F, HB2=0x10 ----
        s0 = slot_bits(24'h123456, 24'hABCDEF);
        s1 = slot_bits(24'h654321, 24'h0FEDCB);
        s2 = slot_bits(24'h00FF00, 24'hFF00FF);
        s3 = slot_bits(24'h800001, 24'h7FFFFE);
        exp_q.push_back({1'b1, 16'hABCD, 16'h1234});
        exp_q.push_back({1'b0, 16'h0FED, 16'h6543});
        exp_q.push_back({1'b0, 16'hFF00, 16'h00FF});
        exp_q.push_back({1'b0, 16'h7FFF, 16'h8000});
        send(24'h100F02, s0, s1, s2, s3, 1'b0);
        chk("audio_valid_c1", 64'(audio_valid), 0);
        idle(1);
        chk("audio_valid_c2", 64'(audio_valid), 1);
        idle(8);
        chk("audio_drained_valid", 64'(audio_valid), 0);
        chk("audio_drained_q", 64'(exp_q.size()), 0);

        // ---- HB1=0x05 (slots 0,2), then layout 1 (no samples) ----
        exp_q.push_back(ex(1'b0, 24'h123456, 24'hABCDEF));
        exp_q.push_back(ex(1'b1, 24'h00FF00, 24'hFF00FF));
        send(24'h400502, s0, s1, s2, s3, 1'b0);
        idle(4);
        send(24'h001F02, s0, s1, s2, s3, 1'b0);
        idle(8);
        chk("sparse_count", 64'(audio_fifo_count), 0);
        chk("sparse_q", 64'(exp_q.size()), 0);

        // ---- overflow: three 4-sample packets with no consumer ----
        audio_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) begin
                l = {8'(8'h10 * (p + 1) + k), 16'h5A00 + 16'(k)};
                r = {8'(8'hC0 + 4 * p + k), 16'h3300 + 16'(p)};
                ov[k] = slot_bits(l, r);
                if (p < 2) begin
                    exp_q.push_back(ex(1'b0, l, r));
                end
            end
            send(24'h000F02, ov[0], ov[1], ov[2], ov[3], 1'b0);
            idle(4);
        end
        idle(2);
        chk("ovf_count", 64'(audio_fifo_count), 8);
        chk("ovf_flag", 64'(audio_overflow), 1);
        chk("ovf_valid", 64'(audio_valid), 1);
        audio_ready = 1'b1;
        idle(12);
        chk("ovf_drain_count", 64'(audio_fifo_count), 0);
        chk("ovf_drain_q", 64'(exp_q.size()), 0);

        // ---- AVI InfoFrame VIC=4, checksum 0x33 ----
        send(24'h0D0282, 56'h00_00_04_00_28_10_33, 56'h0, 56'h0, 56'h0, 1'b0);
        chk("avi_vic_good", 64'(avi_vic), 4);
        chk("avi_cs_err_good", 64'(checksum_error), 0);
        chk("avi_present_early", 64'(avi_present), 0);
        field_end();
        chk("avi_present", 64'(avi_present), 1);
        chk("spd_present_0", 64'(spd_present), 0);
        chk("audio_if_present_0", 64'(audio_if_present), 0);
        // Bad checksum (VIC changed to 5, checksum left at 0x33).
        send(24'h0D0282, 56'h00_00_05_00_28_10_33, 56'h0, 56'h0, 56'h0, 1'b0);
        chk("bad_cs_pulse", 64'(checksum_error), 1);
        chk("bad_cs_vic", 64'(avi_vic), 4);
        idle(1);
        chk("bad_cs_pulse_end", 64'(checksum_error), 0);
        field_end();
        chk("avi_present_after_bad", 64'(avi_present), 0);
        // SPD coinciding with field end counts toward the ending field.
        send(24'h190183, 56'h00_00_00_00_00_00_63, 56'h0, 56'h0, 56'h0, 1'b1);
        chk("spd_same_cycle", 64'(spd_present), 1);
        chk("spd_cs_err", 64'(checksum_error), 0);
        field_end();
        chk("spd_cleared", 64'(spd_present), 0);

        // ---- protocol error: second packet at C+2 during unpack ----
        chk("proto_before", 64'(protocol_error), 0);
        exp_q.push_back(ex(1'b1, 24'h123456, 24'hABCDEF));
        exp_q.push_back(ex(1'b1, 24'h654321, 24'h0FEDCB));
        exp_q.push_back(ex(1'b1, 24'h00FF00, 24'hFF00FF));
        exp_q.push_back(ex(1'b1, 24'h800001, 24'h7FFFFE));
        send(24'hF00F02, s0, s1, s2, s3, 1'b0);
        idle(1);
        send(24'h000001, 56'h12_34_56_78_9A_BC_DE, 56'h0, 56'h0, 56'h0, 1'b0);
        chk("proto_flag", 64'(protocol_error), 1);
        chk("proto_acr_kept", 64'(acr_n), 64'h01800);
        idle(8);
        chk("proto_q", 64'(exp_q.size()), 0);

        // ---- asynchronous reset mid-unpack ----
        audio_ready = 1'b0;
        send(24'h000F02, s0, s1, s2, s3, 1'b0);
        idle(1);
        chk("pre_rst_count", 64'(audio_fifo_count), 1);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(audio_valid), 0);
        chk("arst_count", 64'(audio_fifo_count), 0);
        chk("arst_regs", 64'({acr_n, acr_cts, avi_vic}), 0);
        chk("arst_flags", 64'({audio_overflow, protocol_error, avi_present, spd_present,
                               unpack_active}), 0);
        #1;
        reset_n = 1'b1;
        idle(6);
        chk("post_rst_count", 64'(audio_fifo_count), 0);

        chk("acr_pulses", 64'(acr_pulses), 1);
        chk("final_q", 64'(exp_q.size() + acr_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
